cnn_pixel_streamer: RTL and testbench

CNN_PIXEL_STREAMER -- requirements
Module: cnn_pixel_streamer

---
 rtl/cnn_pixel_streamer_pkg.sv | 17 +
 rtl/cnn_pixel_streamer_if.sv | 36 +++
 rtl/cnn_pixel_streamer_bank.sv | 39 +++
 rtl/cnn_pixel_streamer.sv | 138 +++++++++++++
 tb/tb_cnn_pixel_streamer.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cnn_pixel_streamer_pkg.sv
// Shared CNN defines: default image geometry, pixel width and pixel-index
// width used by the pixel streamer and the conv stages, plus the streamer
// FSM state encoding.
package cnn_pixel_streamer_pkg;

    localparam int CNN_IMG_W  = 28;  // pixels per row
    localparam int CNN_IMG_H  = 28;  // rows per frame
    localparam int CNN_DATA_W = 8;   // pixel width
    localparam int CNN_PIX_W  = 10;  // row-major pixel index width

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRIME,
        ST_STREAM
    } strm_state_e;

endpackage

// File: rtl/cnn_pixel_streamer_if.sv
// Load-side and stream-side signals of the pixel streamer.
//   slave  : the streamer (takes load writes, drives the pixel stream)
//   master : the loader / downstream consumer side
// Load side  : ld_en, ld_addr, ld_data, ld_done -> ; <- ld_ready
// Stream side: <- cnn_data_out, cnn_data_out_valid, sof, eol, eof,
//              frame_done ; cnn_data_out_ready ->
interface cnn_pixel_streamer_if
    import cnn_pixel_streamer_pkg::*;
#(
    parameter int DATA_W = CNN_DATA_W
);
    logic                 ld_en;
    logic [CNN_PIX_W-1:0] ld_addr;
    logic [DATA_W-1:0]    ld_data;
    logic                 ld_done;
    logic                 ld_ready;
    logic [DATA_W-1:0]    cnn_data_out;
    logic                 cnn_data_out_valid;
    logic                 cnn_data_out_ready;
    logic                 sof;
    logic                 eol;
    logic                 eof;
    logic                 frame_done;

    modport slave (
        input  ld_en, ld_addr, ld_data, ld_done, cnn_data_out_ready,
        output ld_ready, cnn_data_out, cnn_data_out_valid, sof, eol, eof,
               frame_done
    );

    modport master (
        output ld_en, ld_addr, ld_data, ld_done, cnn_data_out_ready,
        input  ld_ready, cnn_data_out, cnn_data_out_valid, sof, eol, eof,
               frame_done
    );
endinterface

// File: rtl/cnn_pixel_streamer_bank.sv
// cnn_frame_bank: one frame of pixel storage. Simple dual-port RAM with one
// write port and one synchronous read port (1-cycle latency).
//   clk, rst_n        : clock, async active-low reset (read register only)
//   we_i/waddr_i/wdata_i : write port
//   re_i/raddr_i      : read request; rdata_o updates the cycle after re_i
//   rdata_o           : read data, held while re_i is low
module cnn_frame_bank
    import cnn_pixel_streamer_pkg::*;
#(
    parameter int DEPTH  = CNN_IMG_W * CNN_IMG_H,
    parameter int DATA_W = CNN_DATA_W,
    parameter int AW     = CNN_PIX_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [DATA_W-1:0] rdata_o
);
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Array itself is not reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    // Holding the read register while re_i is low is what keeps the
    // streamed pixel stable during downstream stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    rdata_q <= '0;
        else if (re_i) rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/cnn_pixel_streamer.sv
// cnn_pixel_streamer: double-buffered frame store. A loader fills one bank
// (load pointer lb) while the other bank (stream pointer sb) is streamed out
// row-major, one pixel per cycle, with sof/eol/eof framing.
//   clk, rst_n : clock, async active-low reset
//   bus        : cnn_pixel_streamer_if.slave (load port + pixel stream)
module cnn_pixel_streamer
    import cnn_pixel_streamer_pkg::*;
#(
    parameter int IMG_W  = CNN_IMG_W,
    parameter int IMG_H  = CNN_IMG_H,
    parameter int DATA_W = CNN_DATA_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    cnn_pixel_streamer_if.slave  bus
);
    localparam int AW = CNN_PIX_W;
    localparam logic [AW-1:0] LAST_PIX = AW'(IMG_W * IMG_H - 1);
    localparam logic [AW-1:0] LAST_COL = AW'(IMG_W - 1);
    localparam logic [AW-1:0] LAST_ROW = AW'(IMG_H - 1);

    strm_state_e   state_q;
    logic          lb_q, sb_q;
    logic [1:0]    full_q, full_d;
    logic [AW-1:0] idx_q, col_q, row_q, col_nx, row_nx;
    logic          valid_q, sof_q, eol_q, eof_q, done_q;

    logic          ld_ready, wr_ok, ld_acc, fire, eof_fire, rd_en;
    logic [AW-1:0] rd_addr;
    logic [1:0][DATA_W-1:0] rdata;

    assign ld_ready = ~full_q[lb_q];
    assign wr_ok    = bus.ld_en & ld_ready & (bus.ld_addr <= LAST_PIX);
    assign ld_acc   = bus.ld_done & ld_ready;
    assign fire     = (state_q == ST_STREAM) & valid_q & bus.cnn_data_out_ready;
    assign eof_fire = fire & eof_q;

    // Load completion and stream completion always target different banks,
    // so both updates can land in the same cycle.
    always_comb begin
        full_d = full_q;
        if (ld_acc)   full_d[lb_q] = 1'b1;
        if (eof_fire) full_d[sb_q] = 1'b0;
    end

    always_comb begin
        col_nx = (col_q == LAST_COL) ? '0 : col_q + AW'(1);
        row_nx = (col_q == LAST_COL) ? row_q + AW'(1) : row_q;
    end

    // PRIME fetches pixel 0; each non-final transfer fetches the next pixel
    // so the RAM read register is the output stage.
    assign rd_en   = (state_q == ST_PRIME) | (fire & ~eof_q);
    assign rd_addr = (state_q == ST_PRIME) ? '0 : idx_q + AW'(1);

    for (genvar b = 0; b < 2; b++) begin : g_bank
        cnn_frame_bank #(
            .DEPTH  (IMG_W * IMG_H),
            .DATA_W (DATA_W),
            .AW     (AW)
        ) u_bank (
            .clk     (clk),
            .rst_n   (rst_n),
            .we_i    (wr_ok & (lb_q == 1'(b))),
            .waddr_i (bus.ld_addr),
            .wdata_i (bus.ld_data),
            .re_i    (rd_en & (sb_q == 1'(b))),
            .raddr_i (rd_addr),
            .rdata_o (rdata[b])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            lb_q    <= 1'b0;
            sb_q    <= 1'b0;
            full_q  <= '0;
            idx_q   <= '0;
            col_q   <= '0;
            row_q   <= '0;
            valid_q <= 1'b0;
            sof_q   <= 1'b0;
            eol_q   <= 1'b0;
            eof_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            full_q <= full_d;
            done_q <= 1'b0;
            if (ld_acc) lb_q <= ~lb_q;
            case (state_q)
                // Looking at full_d lets a completing load start priming
                // in the very cycle its ld_done is registered.
                ST_IDLE: if (full_d[sb_q]) state_q <= ST_PRIME;
                ST_PRIME: begin
                    state_q <= ST_STREAM;
                    valid_q <= 1'b1;
                    idx_q   <= '0;
                    col_q   <= '0;
                    row_q   <= '0;
                    sof_q   <= 1'b1;
                    eol_q   <= (LAST_COL == '0);
                    eof_q   <= (LAST_PIX == '0);
                end
                ST_STREAM: begin
                    if (fire && eof_q) begin
                        valid_q <= 1'b0;
                        sof_q   <= 1'b0;
                        eol_q   <= 1'b0;
                        eof_q   <= 1'b0;
                        done_q  <= 1'b1;
                        idx_q   <= '0;
                        col_q   <= '0;
                        row_q   <= '0;
                        sb_q    <= ~sb_q;
                        state_q <= full_d[~sb_q] ? ST_PRIME : ST_IDLE;
                    end else if (fire) begin
                        idx_q <= idx_q + AW'(1);
                        col_q <= col_nx;
                        row_q <= row_nx;
                        sof_q <= 1'b0;
                        eol_q <= (col_nx == LAST_COL);
                        eof_q <= (row_nx == LAST_ROW) && (col_nx == LAST_COL);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.ld_ready           = ld_ready;
    assign bus.cnn_data_out       = rdata[sb_q];
    assign bus.cnn_data_out_valid = valid_q;
    assign bus.sof                = sof_q;
    assign bus.eol                = eol_q;
    assign bus.eof                = eof_q;
    assign bus.frame_done         = done_q;
endmodule

// File: tb/tb_cnn_pixel_streamer.sv
// Bench for cnn_pixel_streamer: a queue-of-frames reference model (at most
// two frames outstanding, frames leave in load order) against a negedge
// monitor that records every transferred beat and frame_done pulse.
module tb_cnn_pixel_streamer;
    import cnn_pixel_streamer_pkg::*;

    localparam int W  = 28;
    localparam int H  = 28;
    localparam int NP = W * H;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cnn_pixel_streamer_if #(.DATA_W(8)) bus();
    cnn_pixel_streamer #(.IMG_W(W), .IMG_H(H), .DATA_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [7:0] d;
        logic       sof, eol, eof;
        int         cyc;
    } beat_t;

    beat_t beats[$];
    int    fd_cyc[$];
    int    stall_bad = 0, stall_cnt = 0, cyc = 0;
    logic  stall_prev = 1'b0;
    logic [10:0] prev_o = '0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!rst_n) stall_prev = 1'b0;
        else begin
            if (stall_prev) begin
                stall_cnt++;
                if (!bus.cnn_data_out_valid ||
                    {bus.cnn_data_out, bus.sof, bus.eol, bus.eof} !== prev_o)
                    stall_bad++;
            end
            if (bus.cnn_data_out_valid && bus.cnn_data_out_ready)
                beats.push_back(beat_t'{bus.cnn_data_out, bus.sof, bus.eol, bus.eof, cyc});
            if (bus.frame_done) fd_cyc.push_back(cyc);
            stall_prev = bus.cnn_data_out_valid && !bus.cnn_data_out_ready;
            prev_o = {bus.cnn_data_out, bus.sof, bus.eol, bus.eof};
        end
    end

    // Reference model
    logic [7:0] mdl_img [NP];
    logic [7:0] exp_pix [$];
    int         pending = 0;
    int         vecs = 0, errs = 0;
    bit         rdy_stop;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_px(input logic [9:0] a, input logic [7:0] d);
        bus.ld_en = 1'b1; bus.ld_addr = a; bus.ld_data = d;
        if (pending < 2 && a < 10'(NP)) mdl_img[a] = d;
        tick();
        bus.ld_en = 1'b0;
    endtask

    task automatic pulse_done(output int t);
        bus.ld_done = 1'b1;
        t = cyc;
        if (pending < 2) begin
            for (int i = 0; i < NP; i++) exp_pix.push_back(mdl_img[i]);
            pending++;
        end
        tick();
        bus.ld_done = 1'b0;
    endtask

    task automatic load_frame(input bit rnd, output int t);
        for (int i = 0; i < NP; i++)
            write_px(10'(i), rnd ? 8'($urandom_range(0, 255)) : 8'(i % 256));
        pulse_done(t);
    endtask

    task automatic wait_fd(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            if (fd_cyc.size() >= n) begin ok = 1'b1; break; end
            tick();
        end
    endtask

    task automatic test_reset();
        bus.ld_en = 0; bus.ld_addr = '0; bus.ld_data = '0; bus.ld_done = 0;
        bus.cnn_data_out_ready = 0;
        rst_n = 1'b0;
        repeat (3) tick();
        vecs++; if (bus.cnn_data_out_valid !== 1'b0) begin errs++; $display("FAIL rst_valid got %b want 0", bus.cnn_data_out_valid); end
        vecs++; if (bus.cnn_data_out !== 8'd0) begin errs++; $display("FAIL rst_data got %0d want 0", bus.cnn_data_out); end
        vecs++; if ({bus.sof, bus.eol, bus.eof} !== 3'b000) begin errs++; $display("FAIL rst_flags got %b want 000", {bus.sof, bus.eol, bus.eof}); end
        vecs++; if (bus.frame_done !== 1'b0) begin errs++; $display("FAIL rst_frame_done got %b want 0", bus.frame_done); end
        vecs++; if (bus.ld_ready !== 1'b1) begin errs++; $display("FAIL rst_ld_ready got %b want 1", bus.ld_ready); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_frame();
        int b0, f0, t, n, gap, eols;
        bit ok;
        beat_t b;
        logic [7:0] e;
        b0 = beats.size(); f0 = fd_cyc.size();
        bus.cnn_data_out_ready = 1'b1;
        load_frame(1'b0, t);
        wait_fd(f0 + 1, 2000, ok);
        vecs++; if (!ok) begin errs++; $display("FAIL sf_timeout got no frame_done want one"); end
        n = beats.size() - b0;
        vecs++; if (n != NP) begin errs++; $display("FAIL sf_count got %0d want %0d", n, NP); end
        vecs++;
        if (n == 0) begin errs++; $display("FAIL sf_latency got no beat want cycle %0d", t + 2); end
        else if (beats[b0].cyc != t + 2) begin errs++; $display("FAIL sf_latency got cycle %0d want %0d", beats[b0].cyc, t + 2); end
        gap = 0; eols = 0;
        for (int i = 0; i < NP; i++) begin
            e = exp_pix.pop_front();
            if (i < n) begin
                b = beats[b0 + i];
                vecs++;
                if (b.d !== e || b.sof !== (i == 0) || b.eol !== (i % W == W - 1) || b.eof !== (i == NP - 1)) begin
                    errs++;
                    $display("FAIL sf_beat[%0d] got d=%0d sof=%b eol=%b eof=%b want d=%0d sof=%b eol=%b eof=%b",
                             i, b.d, b.sof, b.eol, b.eof, e, i == 0, i % W == W - 1, i == NP - 1);
                end
                if (b.cyc != beats[b0].cyc + i) gap++;
                if (b.eol) eols++;
            end
        end
        pending--;
        vecs++; if (gap != 0) begin errs++; $display("FAIL sf_bubbles got %0d want 0", gap); end
        vecs++; if (eols != H) begin errs++; $display("FAIL sf_eol_count got %0d want %0d", eols, H); end
        vecs++;
        if (!ok || n < NP) begin errs++; $display("FAIL sf_frame_done got missing want eof+1"); end
        else if (fd_cyc[f0] != beats[b0 + NP - 1].cyc + 1) begin
            errs++; $display("FAIL sf_frame_done got cycle %0d want %0d", fd_cyc[f0], beats[b0 + NP - 1].cyc + 1);
        end
        tick();
        vecs++; if (bus.ld_ready !== (pending < 2)) begin errs++; $display("FAIL sf_ld_ready got %b want %b", bus.ld_ready, pending < 2); end
    endtask

    task automatic test_stall();
        int b0, f0, s0, c0, t, n;
        bit ok;
        beat_t b;
        logic [7:0] e;
        b0 = beats.size(); f0 = fd_cyc.size(); s0 = stall_bad; c0 = stall_cnt;
        rdy_stop = 1'b0;
        ok = 1'b0;
        fork
            begin
                load_frame(1'b1, t);
                wait_fd(f0 + 1, 4000, ok);
                rdy_stop = 1'b1;
            end
            begin
                while (!rdy_stop) begin
                    bus.cnn_data_out_ready = 1'($urandom_range(0, 1));
                    tick();
                end
            end
        join
        bus.cnn_data_out_ready = 1'b1;
        vecs++; if (!ok) begin errs++; $display("FAIL st_timeout got no frame_done want one"); end
        n = beats.size() - b0;
        vecs++; if (n != NP) begin errs++; $display("FAIL st_count got %0d want %0d", n, NP); end
        for (int i = 0; i < NP; i++) begin
            e = exp_pix.pop_front();
            if (i < n) begin
                b = beats[b0 + i];
                vecs++;
                if (b.d !== e || b.sof !== (i == 0) || b.eol !== (i % W == W - 1) || b.eof !== (i == NP - 1)) begin
                    errs++;
                    $display("FAIL st_beat[%0d] got d=%0d flags=%b%b%b want d=%0d", i, b.d, b.sof, b.eol, b.eof, e);
                end
            end
        end
        pending--;
        vecs++; if (stall_bad != s0) begin errs++; $display("FAIL st_hold got %0d unstable stalls want 0", stall_bad - s0); end
        vecs++; if (stall_cnt == c0) begin errs++; $display("FAIL st_stalls got 0 stall cycles want >0"); end
    endtask

    task automatic test_back_to_back();
        int b0, f0, s0, t, n;
        bit ok;
        beat_t b;
        logic [7:0] e;
        b0 = beats.size(); f0 = fd_cyc.size(); s0 = stall_bad;
        bus.cnn_data_out_ready = 1'b0;
        load_frame(1'b1, t);
        vecs++; if (bus.ld_ready !== (pending < 2)) begin errs++; $display("FAIL bb_ready_a got %b want %b", bus.ld_ready, pending < 2); end
        load_frame(1'b1, t);
        vecs++; if (bus.ld_ready !== (pending < 2)) begin errs++; $display("FAIL bb_ready_b got %b want %b", bus.ld_ready, pending < 2); end
        for (int k = 0; k < 16; k++)
            write_px(10'($urandom_range(0, NP - 1)), 8'($urandom_range(0, 255)));
        write_px(10'd800, 8'hA5);
        pulse_done(t);
        vecs++; if (bus.ld_ready !== (pending < 2)) begin errs++; $display("FAIL bb_ready_junk got %b want %b", bus.ld_ready, pending < 2); end
        bus.cnn_data_out_ready = 1'b1;
        wait_fd(f0 + 2, 4000, ok);
        vecs++; if (!ok) begin errs++; $display("FAIL bb_timeout got %0d frame_done want 2", fd_cyc.size() - f0); end
        n = beats.size() - b0;
        vecs++; if (n != 2 * NP) begin errs++; $display("FAIL bb_count got %0d want %0d", n, 2 * NP); end
        for (int i = 0; i < 2 * NP; i++) begin
            e = exp_pix.pop_front();
            if (i < n) begin
                b = beats[b0 + i];
                vecs++;
                if (b.d !== e || b.sof !== (i % NP == 0) || b.eol !== (i % W == W - 1) || b.eof !== (i % NP == NP - 1)) begin
                    errs++;
                    $display("FAIL bb_beat[%0d] got d=%0d flags=%b%b%b want d=%0d", i, b.d, b.sof, b.eol, b.eof, e);
                end
            end
        end
        pending -= 2;
        vecs++;
        if (n < NP + 1) begin errs++; $display("FAIL bb_gap got missing frame 1 want sof at eof+2"); end
        else if (beats[b0 + NP].cyc != beats[b0 + NP - 1].cyc + 2) begin
            errs++; $display("FAIL bb_gap got %0d cycles want 2", beats[b0 + NP].cyc - beats[b0 + NP - 1].cyc);
        end
        vecs++; if (stall_bad != s0) begin errs++; $display("FAIL bb_hold got %0d unstable stalls want 0", stall_bad - s0); end
        tick();
        vecs++; if (bus.ld_ready !== (pending < 2)) begin errs++; $display("FAIL bb_ready_end got %b want %b", bus.ld_ready, pending < 2); end
    endtask

    task automatic test_reset_mid_frame();
        int b0, b1, f0, t, n, hv;
        bit ok;
        beat_t b;
        logic [7:0] e;
        b0 = beats.size();
        bus.cnn_data_out_ready = 1'b1;
        load_frame(1'b1, t);
        ok = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            if (beats.size() >= b0 + 300) begin ok = 1'b1; break; end
            tick();
        end
        vecs++; if (!ok) begin errs++; $display("FAIL rm_reach300 got %0d beats want 300", beats.size() - b0); end
        rst_n = 1'b0;
        #1;
        pending = 0;
        exp_pix.delete();
        vecs++; if (bus.cnn_data_out_valid !== 1'b0) begin errs++; $display("FAIL rm_valid got %b want 0", bus.cnn_data_out_valid); end
        vecs++; if (bus.cnn_data_out !== 8'd0) begin errs++; $display("FAIL rm_data got %0d want 0", bus.cnn_data_out); end
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        vecs++; if (bus.ld_ready !== 1'b1) begin errs++; $display("FAIL rm_ld_ready got %b want 1", bus.ld_ready); end
        b1 = beats.size(); hv = 0;
        repeat (40) begin
            if (bus.cnn_data_out_valid) hv++;
            tick();
        end
        vecs++; if (hv != 0 || beats.size() != b1) begin errs++; $display("FAIL rm_quiet got %0d valid cycles want 0", hv); end
        f0 = fd_cyc.size();
        load_frame(1'b1, t);
        wait_fd(f0 + 1, 2000, ok);
        n = beats.size() - b1;
        vecs++; if (!ok || n != NP) begin errs++; $display("FAIL rm_count got %0d want %0d", n, NP); end
        vecs++;
        if (n == 0) begin errs++; $display("FAIL rm_latency got no beat want cycle %0d", t + 2); end
        else if (beats[b1].cyc != t + 2) begin errs++; $display("FAIL rm_latency got cycle %0d want %0d", beats[b1].cyc, t + 2); end
        for (int i = 0; i < NP; i++) begin
            e = exp_pix.pop_front();
            if (i < n) begin
                b = beats[b1 + i];
                vecs++;
                if (b.d !== e || b.sof !== (i == 0) || b.eof !== (i == NP - 1)) begin
                    errs++;
                    $display("FAIL rm_beat[%0d] got d=%0d sof=%b eof=%b want d=%0d", i, b.d, b.sof, b.eof, e);
                end
            end
        end
        pending--;
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_stall();
        test_back_to_back();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
